// File: rtl/stn_capture_if.sv
// Panel-side bus plus frame-buffer write port of the STN capture stage.
// The master side drives the panel pins and controls; the slave is the capture block.
interface stn_capture_if #(
    parameter int AW = 14
);
    logic          P_FPFRAME;
    logic          P_FPLINE;
    logic          P_FPSHIFT;
    logic [3:0]    P_FPDAT;
    logic          cap_en;
    logic          err_clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic          err_pix;
    logic          err_line;
    logic          state_sync;

    modport master (
        output P_FPFRAME, P_FPLINE, P_FPSHIFT, P_FPDAT, cap_en, err_clr,
        input  wr_en, wr_addr, wr_data, frame_done, frame_cnt,
               err_pix, err_line, state_sync
    );

    modport slave (
        input  P_FPFRAME, P_FPLINE, P_FPSHIFT, P_FPDAT, cap_en, err_clr,
        output wr_en, wr_addr, wr_data, frame_done, frame_cnt,
               err_pix, err_line, state_sync
    );
endinterface

// File: rtl/stn_capture.sv
// STN 4-bit panel capture: packs nibble pairs into bytes for a linear frame buffer
// and checks per-line shift count and per-frame line count.
//
//   state     | meaning
//   ST_SYNC   | no writes; waiting for a line edge with the frame flag set
//   ST_ACTIVE | capturing nibbles, closing lines and frames
module stn_capture #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int AW      = 14
) (
    input  logic         P_CLK,
    input  logic         P_RST,
    stn_capture_if.slave cap
);

    localparam int BPL = H_PIX / 8;
    localparam int SPL = H_PIX / 4;
    localparam int BW  = $clog2(BPL + 1);
    localparam int SW  = $clog2(SPL + 2);
    localparam int LW  = $clog2(V_LINES + 1);

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          s1_frame_q, s1_line_q, s1_shift_q;
    logic [3:0]    s1_dat_q;
    logic          s2_line_q, s2_shift_q;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] shift_cnt_q, shift_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] base_q, base_d;
    logic          phase_q, phase_d;
    logic [3:0]    hi_q, hi_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          err_pix_q, err_pix_d;
    logic          err_line_q, err_line_d;

    logic          shift_fall, line_edge, byte_full, line_full;
    logic          pix_err, line_err;

    assign shift_fall = s2_shift_q & ~s1_shift_q;
    assign line_edge  = s1_line_q & ~s2_line_q;
    assign byte_full  = (byte_cnt_q == BW'(BPL));
    assign line_full  = (line_cnt_q == LW'(V_LINES));

    always_ff @(posedge P_CLK) begin
        if (P_RST) begin
            s1_frame_q   <= 1'b0;
            s1_line_q    <= 1'b0;
            s1_shift_q   <= 1'b0;
            s1_dat_q     <= 4'h0;
            s2_line_q    <= 1'b0;
            s2_shift_q   <= 1'b0;
            state_q      <= ST_SYNC;
            line_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shift_cnt_q  <= '0;
            addr_q       <= '0;
            base_q       <= '0;
            phase_q      <= 1'b0;
            hi_q         <= 4'h0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
            err_pix_q    <= 1'b0;
            err_line_q   <= 1'b0;
        end else begin
            s1_frame_q   <= cap.P_FPFRAME;
            s1_line_q    <= cap.P_FPLINE;
            s1_shift_q   <= cap.P_FPSHIFT;
            s1_dat_q     <= cap.P_FPDAT;
            s2_line_q    <= s1_line_q;
            s2_shift_q   <= s1_shift_q;
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_cnt_q  <= shift_cnt_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_pix_q    <= err_pix_d;
            err_line_q   <= err_line_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_cnt_d  = shift_cnt_q;
        addr_d       = addr_q;
        base_d       = base_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        pix_err      = 1'b0;
        line_err     = 1'b0;

        // Dropping cap_en abandons the frame silently: no close, no errors.
        if (!cap.cap_en) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (line_edge && s1_frame_q) begin
                        state_d     = ST_ACTIVE;
                        line_cnt_d  = '0;
                        byte_cnt_d  = '0;
                        shift_cnt_d = '0;
                        addr_d      = '0;
                        base_d      = '0;
                        phase_d     = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (shift_fall) begin
                        if (shift_cnt_q != SW'(SPL + 1))
                            shift_cnt_d = shift_cnt_q + SW'(1);
                        if (byte_full || line_full) begin
                            pix_err  = byte_full;
                            line_err = line_full;
                        end else if (!phase_q) begin
                            hi_d    = s1_dat_q;
                            phase_d = 1'b1;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = {hi_q, s1_dat_q};
                            addr_d     = addr_q + AW'(1);
                            byte_cnt_d = byte_cnt_q + BW'(1);
                            phase_d    = 1'b0;
                        end
                    end
                    // Line close sees the shift of this same cycle via shift_cnt_d.
                    if (line_edge) begin
                        if (shift_cnt_d != '0) begin
                            if (shift_cnt_d != SW'(SPL))
                                pix_err = 1'b1;
                            if (!line_full) begin
                                line_cnt_d = line_cnt_q + LW'(1);
                                base_d     = base_q + AW'(BPL);
                            end
                            addr_d      = base_d;
                            byte_cnt_d  = '0;
                            shift_cnt_d = '0;
                            phase_d     = 1'b0;
                        end
                        if (s1_frame_q) begin
                            if (line_cnt_d != LW'(V_LINES))
                                line_err = 1'b1;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            line_cnt_d   = '0;
                            base_d       = '0;
                            addr_d       = '0;
                            byte_cnt_d   = '0;
                            shift_cnt_d  = '0;
                            phase_d      = 1'b0;
                        end
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end

        err_pix_d  = pix_err  | (err_pix_q  & ~cap.err_clr);
        err_line_d = line_err | (err_line_q & ~cap.err_clr);
    end

    assign cap.wr_en      = wr_en_q;
    assign cap.wr_addr    = wr_addr_q;
    assign cap.wr_data    = wr_data_q;
    assign cap.frame_done = frame_done_q;
    assign cap.frame_cnt  = frame_cnt_q;
    assign cap.err_pix    = err_pix_q;
    assign cap.err_line   = err_line_q;
    assign cap.state_sync = (state_q == ST_SYNC);

endmodule

// File: tb/tb_stn_capture.sv
// Directed bench for stn_capture on a reduced 32x12 panel (4 bytes/line, 48 bytes/frame).
// Writes and frame_done pulses are logged on the falling clock edge.
module tb_stn_capture;

    localparam int H   = 32;
    localparam int V   = 12;
    localparam int AWT = 6;
    localparam int SPL = H / 4;
    localparam int BPL = H / 8;

    logic clk;
    logic rst;

    stn_capture_if #(.AW(AWT)) bus ();

    stn_capture #(.H_PIX(H), .V_LINES(V), .AW(AWT)) dut (
        .P_CLK (clk),
        .P_RST (rst),
        .cap   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         nwr = 0;
    int         nfd = 0;
    logic [7:0] log_a [0:1023];
    logic [7:0] log_d [0:1023];

    always @(negedge clk) begin
        if (bus.wr_en && nwr < 1024) begin
            log_a[nwr] = 8'(bus.wr_addr);
            log_d[nwr] = bus.wr_data;
            nwr = nwr + 1;
        end
        if (bus.frame_done) nfd = nfd + 1;
    end

    int pat_mode = 0;
    int g        = 0;
    int hot_ln   = -1;
    int hot_sh   = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic shift(input logic [3:0] nib);
        bus.P_FPDAT   = nib;
        bus.P_FPSHIFT = 1'b1;
        repeat (2) @(negedge clk);
        bus.P_FPSHIFT = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic line_pulse(input logic frm);
        bus.P_FPFRAME = frm;
        bus.P_FPLINE  = 1'b1;
        repeat (2) @(negedge clk);
        bus.P_FPLINE  = 1'b0;
        bus.P_FPFRAME = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int ns, input logic frm, input int ln);
        for (int s = 0; s < ns; s++) begin
            logic [3:0] nib;
            if (pat_mode != 0) begin
                nib = g[3:0];
                g   = g + 1;
            end else begin
                nib = (ln == hot_ln && s == hot_sh) ? 4'hF : 4'h0;
            end
            shift(nib);
        end
        line_pulse(frm);
    endtask

    task automatic send_frame(input int nl);
        for (int l = 0; l < nl; l++) send_line(SPL, (l == nl - 1), l);
    endtask

    // Clean counting frame: write i lands at address i with nibbles 2i, 2i+1 (mod 16).
    task automatic check_clean(input string tag, input int b);
        int aerr, derr, expd;
        aerr = 0;
        derr = 0;
        for (int i = 0; i < V * BPL; i++) begin
            expd = (((2 * i) % 16) << 4) | ((2 * i + 1) % 16);
            if (int'(log_a[b + i]) != i) aerr++;
            if (int'(log_d[b + i]) != expd) derr++;
        end
        chk({tag, "_nwr"}, 32'(nwr - b), 32'(V * BPL));
        chk({tag, "_addr_errs"}, 32'(aerr), 32'd0);
        chk({tag, "_data_errs"}, 32'(derr), 32'd0);
        chk({tag, "_byte0"}, 32'(log_d[b]), 32'h01);
    endtask

    int b0, f0, nz;

    initial begin
        rst           = 1'b1;
        bus.P_FPFRAME = 1'b0;
        bus.P_FPLINE  = 1'b0;
        bus.P_FPSHIFT = 1'b0;
        bus.P_FPDAT   = 4'h0;
        bus.cap_en    = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_errs", {30'd0, bus.err_pix, bus.err_line}, 32'd0);
        chk("rst_sync", 32'(bus.state_sync), 32'd1);

        // Clean frame
        bus.cap_en = 1'b1;
        line_pulse(1'b1);
        chk("sync_left", 32'(bus.state_sync), 32'd0);
        b0 = nwr; f0 = nfd;
        pat_mode = 1; g = 0;
        send_frame(V);
        check_clean("clean", b0);
        chk("clean_fd", 32'(nfd - f0), 32'd1);
        chk("clean_fcnt", 32'(bus.frame_cnt), 32'd1);
        chk("clean_errs", {30'd0, bus.err_pix, bus.err_line}, 32'd0);

        // Single hot pixel: line 5, shift 5 -> byte 5*4+2 = 22 reads 0x0F
        b0 = nwr; f0 = nfd;
        pat_mode = 0; hot_ln = 5; hot_sh = 5;
        send_frame(V);
        nz = 0;
        for (int i = b0; i < nwr; i++) begin
            if (log_a[i] == 8'd22) chk("hot_byte", 32'(log_d[i]), 32'h0F);
            else if (log_d[i] != 8'h00) nz++;
        end
        chk("hot_nwr", 32'(nwr - b0), 32'(V * BPL));
        chk("hot_others", 32'(nz), 32'd0);
        chk("hot_fcnt", 32'(bus.frame_cnt), 32'd2);
        chk("hot_errs", {30'd0, bus.err_pix, bus.err_line}, 32'd0);

        // Short line (7 shifts): half byte dropped, next line still at 4
        hot_ln = -1; hot_sh = -1;
        b0 = nwr;
        send_line(SPL - 1, 1'b0, 0);
        chk("short_err_pix", 32'(bus.err_pix), 32'd1);
        chk("short_nwr", 32'(nwr - b0), 32'd3);
        send_line(SPL, 1'b0, 1);
        chk("short_next_addr", 32'(log_a[b0 + 3]), 32'd4);
        chk("short_next_nwr", 32'(nwr - b0), 32'd7);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("errclr_pix", 32'(bus.err_pix), 32'd0);
        for (int l = 2; l < V; l++) send_line(SPL, (l == V - 1), l);
        chk("short_frame_fcnt", 32'(bus.frame_cnt), 32'd3);
        chk("short_frame_errs", {30'd0, bus.err_pix, bus.err_line}, 32'd0);

        // Frame closed one line early
        f0 = nfd;
        send_frame(V - 1);
        chk("early_err_line", 32'(bus.err_line), 32'd1);
        chk("early_fd", 32'(nfd - f0), 32'd1);
        chk("early_fcnt", 32'(bus.frame_cnt), 32'd4);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("errclr_line", 32'(bus.err_line), 32'd0);

        // One line too many: extra line produces no writes
        b0 = nwr;
        for (int l = 0; l < V; l++) send_line(SPL, 1'b0, l);
        chk("extra_pre_err", 32'(bus.err_line), 32'd0);
        send_line(SPL, 1'b1, V);
        chk("extra_nwr", 32'(nwr - b0), 32'(V * BPL));
        chk("extra_err_line", 32'(bus.err_line), 32'd1);
        chk("extra_err_pix", 32'(bus.err_pix), 32'd0);
        chk("extra_fcnt", 32'(bus.frame_cnt), 32'd5);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;

        // cap_en lowered mid-frame, then raised mid-frame
        for (int l = 0; l < 3; l++) send_line(SPL, 1'b0, l);
        bus.cap_en = 1'b0;
        @(negedge clk);
        chk("capoff_sync", 32'(bus.state_sync), 32'd1);
        b0 = nwr; f0 = nfd;
        for (int l = 3; l < V; l++) send_line(SPL, (l == V - 1), l);
        chk("capoff_nwr", 32'(nwr - b0), 32'd0);
        chk("capoff_fd", 32'(nfd - f0), 32'd0);
        chk("capoff_fcnt", 32'(bus.frame_cnt), 32'd5);
        bus.cap_en = 1'b1;
        for (int l = 0; l < 4; l++) send_line(SPL, 1'b0, l);
        send_line(SPL, 1'b1, 4);
        chk("capon_nwr", 32'(nwr - b0), 32'd0);
        chk("capon_fd", 32'(nfd - f0), 32'd0);
        chk("capon_errs", {30'd0, bus.err_pix, bus.err_line}, 32'd0);
        chk("capon_active", 32'(bus.state_sync), 32'd0);
        b0 = nwr;
        pat_mode = 1; g = 0;
        send_frame(V);
        check_clean("capon", b0);
        chk("capon_fcnt", 32'(bus.frame_cnt), 32'd6);

        // Reset in the middle of a write burst, cancelling a pending write
        pat_mode = 0;
        send_line(SPL, 1'b0, 0);
        for (int s = 0; s < 3; s++) shift(4'h5);
        bus.P_FPDAT   = 4'hA;
        bus.P_FPSHIFT = 1'b1;
        repeat (2) @(negedge clk);
        bus.P_FPSHIFT = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("mrst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("mrst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("mrst_fcnt", 32'(bus.frame_cnt), 32'd0);
        chk("mrst_sync", 32'(bus.state_sync), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_flags", {29'd0, bus.frame_done, bus.err_pix, bus.err_line}, 32'd0);
        line_pulse(1'b1);
        b0 = nwr; f0 = nfd;
        pat_mode = 1; g = 0;
        send_frame(V);
        check_clean("postrst", b0);
        chk("postrst_fd", 32'(nfd - f0), 32'd1);
        chk("postrst_fcnt", 32'(bus.frame_cnt), 32'd1);
        chk("postrst_errs", {30'd0, bus.err_pix, bus.err_line}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
